prbs15_checker: RTL and testbench
=================================

# prbs15_checker

Serial PRBS-15 checker sitting directly downstream of the 15-bit LFSR generator; it consumes the generator's registered serial output bit stream. The block self-synchronises to the x^15 + x^14 + 1 sequence, declares lock, then counts bit errors and observed bits until lock is lost. It is used as the link/loopback receiver in self-test of the adder datapath.

## Interface
- UNLOCK_WINDOW, 64: bits per error-rate evaluation window while locked.
- UNLOCK_ERRORS, 8: errors within one window that force loss of lock (1..UNLOCK_WINDOW).
- LOCK_COUNT, 16: consecutive correctly predicted bits required to declare lock.
- CNT_WIDTH, 16: width of err_count and bit_count.

- clk  input  1  rising-edge clock.
- sync_reset  input  1  synchronous, active-high reset.
- enable  input  1  data_in valid this cycle; low means hold all state (generator paused or loading).
- data_in  input  1  received serial bit.
- clear_counts  input  1  synchronous clear of err_count and bit_count; lock state unaffected.
- locked  output  1  registered; high while in LOCKED.
- error_pulse  output  1  registered; one-cycle pulse for each mismatched bit in LOCKED.
- err_count  output  CNT_WIDTH  saturating count of mismatches in LOCKED.
- bit_count  output  CNT_WIDTH  saturating count of bits checked in LOCKED.

## Operation
- Internal 15-bit history r[15:1], r[1] newest; prediction p = r[14] ^ r[15]; a bit shifts in as r[15:2] <= r[14:1], r[1] <= new bit.
- All state changes occur only on cycles with enable=1; enable=0 freezes everything, error_pulse forced 0.
- States:
  - SEED: shift data_in into r; fill counter 0..15; after the 15th valid bit go to VERIFY, match counter = 0.
  - VERIFY: compare data_in with p, shift data_in. Match: match counter +1; reaching LOCK_COUNT -> LOCKED, window/error-window counters = 0. Mismatch -> SEED, fill counter = 0. If r == 0 after the shift -> SEED (all-zero stream is not valid PRBS).
  - LOCKED: compare data_in with p; shift p (not data_in), so one flipped input bit counts as exactly one error. bit_count +1; on mismatch err_count +1, window-error +1, error_pulse=1. Window counter wraps at UNLOCK_WINDOW, clearing window-error. Window-error reaching UNLOCK_ERRORS -> SEED (fill counter = 0); err_count/bit_count retained.
- Counters saturate at all-ones; no wrap.
- clear_counts with a simultaneous counted bit: clear wins, that bit/error is not counted; error_pulse still fires.
- sync_reset mid-operation: returns to SEED on next edge regardless of enable, discarding partial fill/verify/window progress.

## Timing
- Reset values: locked=0, error_pulse=0, err_count=0, bit_count=0, r=0, state=SEED, all internal counters 0.
- Lock latency: minimum 15 + LOCK_COUNT valid bits from first clean bit; locked rises on the edge that accepts the LOCK_COUNT-th match.
- error_pulse and err_count update on the same edge that samples the mismatched bit (1-cycle registered latency from data_in).
- locked falls on the edge that samples the UNLOCK_ERRORS-th error of a window; that error still pulses and counts.
- Inputs sampled only on rising clk; no combinational input-to-output paths.

## Test plan
- Reset, then 200 valid bits of clean PRBS-15 from generator seed 15'h7FFF -> locked rises exactly at bit 31, err_count=0, bit_count=169, no error_pulse.
- Locked, invert one bit at stream position 100 -> single error_pulse, err_count=1, locked stays 1, following bits all match.
- Locked, invert 8 bits within one 64-bit window -> locked falls on the 8th error, err_count=8, relock after 31 further clean bits.
- Feed constant 0 for 100 bits -> never locked, state cycles SEED/VERIFY; then clean stream -> locks.
- Toggle enable low for random gaps (including mid-SEED and mid-VERIFY) on clean stream -> identical lock point and counts as gap-free run.
- Assert clear_counts on a cycle with an injected error -> err_count=0 next edge, error_pulse=1; assert sync_reset while locked -> locked=0 next edge.

Source files
------------

// File: rtl/prbs15_checker.sv
// Serial PRBS-15 (x^15 + x^14 + 1) checker. Self-synchronises to the incoming
// stream, declares lock, then counts errors and checked bits while locked.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_SEED   | loading 15 received bits into the history register
//   ST_VERIFY | predicting from received history; counting clean matches
//   ST_LOCKED | predicting from self-generated history; counting errors
module prbs15_checker #(
   parameter int UNLOCK_WINDOW = 64,
   parameter int UNLOCK_ERRORS = 8,
   parameter int LOCK_COUNT    = 16,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 sync_reset,
   input  logic                 enable,
   input  logic                 data_in,
   input  logic                 clear_counts,
   output logic                 locked,
   output logic                 error_pulse,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic [CNT_WIDTH-1:0] bit_count
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int WW = $clog2(UNLOCK_WINDOW + 1);
   localparam int EW = $clog2(UNLOCK_ERRORS + 1);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [15:1]           r_q, r_d;
   logic [3:0]            fill_q, fill_d;
   logic [MW-1:0]         match_q, match_d;
   logic [WW-1:0]         win_q, win_d;
   logic [EW-1:0]         werr_q, werr_d;
   logic [CNT_WIDTH-1:0]  err_d, bit_d;
   logic                  pulse_d;
   logic                  pred;
   logic                  mism;
   logic [15:1]           shifted_in;

   // Next-state, history, counter and pulse computation; holds everything when enable is low.
   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      fill_d     = fill_q;
      match_d    = match_q;
      win_d      = win_q;
      werr_d     = werr_q;
      err_d      = err_count;
      bit_d      = bit_count;
      pulse_d    = 1'b0;
      pred       = r_q[14] ^ r_q[15];
      mism       = data_in ^ pred;
      shifted_in = {r_q[14:1], data_in};

      if (enable) begin
         unique case (state_q)
            ST_SEED: begin
               r_d = shifted_in;
               if (fill_q == 4'd14) begin
                  state_d = ST_VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + 4'd1;
               end
            end
            ST_VERIFY: begin
               r_d = shifted_in;
               // An all-zero history is a stuck stream, not a PRBS phase.
               if (mism || (shifted_in == '0)) begin
                  state_d = ST_SEED;
                  fill_d  = '0;
               end else if (match_q == MW'(LOCK_COUNT - 1)) begin
                  state_d = ST_LOCKED;
                  win_d   = '0;
                  werr_d  = '0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               // Shifting the prediction keeps one flipped bit from echoing as later errors.
               r_d     = {r_q[14:1], pred};
               pulse_d = mism;
               if (!(&bit_count)) bit_d = bit_count + 1'b1;
               if (mism && !(&err_count)) err_d = err_count + 1'b1;
               if (mism && (werr_q == EW'(UNLOCK_ERRORS - 1))) begin
                  state_d = ST_SEED;
                  fill_d  = '0;
               end else if (win_q == WW'(UNLOCK_WINDOW - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
               end else begin
                  win_d = win_q + 1'b1;
                  if (mism) werr_d = werr_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_SEED;
               fill_d  = '0;
            end
         endcase
         if (clear_counts) begin
            err_d = '0;
            bit_d = '0;
         end
      end
   end

   // State register and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q     <= ST_SEED;
         r_q         <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_q       <= '0;
         werr_q      <= '0;
         locked      <= 1'b0;
         error_pulse <= 1'b0;
         err_count   <= '0;
         bit_count   <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         locked      <= (state_d == ST_LOCKED);
         error_pulse <= pulse_d;
         err_count   <= err_d;
         bit_count   <= bit_d;
      end
   end

endmodule

// File: tb/tb_prbs15_checker.sv
// Self-checking bench for prbs15_checker: scenario table, hand-written corner
// sequences and a randomized run, all against a queue-based reference model.
module tb_prbs15_checker;

   localparam int UW = 64;
   localparam int UE = 8;
   localparam int LC = 16;
   localparam int CW = 8;
   localparam int SATMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          sync_reset;
   logic          enable;
   logic          data_in;
   logic          clear_counts;
   logic          locked;
   logic          error_pulse;
   logic [CW-1:0] err_count;
   logic [CW-1:0] bit_count;

   prbs15_checker #(
      .UNLOCK_WINDOW(UW),
      .UNLOCK_ERRORS(UE),
      .LOCK_COUNT(LC),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .sync_reset(sync_reset),
      .enable(enable),
      .data_in(data_in),
      .clear_counts(clear_counts),
      .locked(locked),
      .error_pulse(error_pulse),
      .err_count(err_count),
      .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit stream[$];
   int sp;

   // reference model: mode 0 = hunting seed, 1 = verifying, 2 = locked
   int m_mode, m_fill, m_match, m_wpos, m_werr, m_ecnt, m_bcnt;
   bit m_hist[$];
   bit m_pulse, m_lock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
      m_ecnt = 0; m_bcnt = 0; m_pulse = 0; m_lock = 0;
      m_hist = {};
      for (int i = 0; i < 15; i++) m_hist.push_back(1'b0);
   endtask

   task automatic push_hist(input bit b);
      m_hist.push_front(b);
      void'(m_hist.pop_back());
   endtask

   function automatic bit hist_zero();
      foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit en, input bit rst, input bit d, input bit clr);
      bit pred, e;
      if (rst) begin
         model_reset();
         return;
      end
      m_pulse = 0;
      if (!en) return;
      pred = m_hist[13] ^ m_hist[14];
      case (m_mode)
         0: begin
            push_hist(d);
            m_fill++;
            if (m_fill == 15) begin m_mode = 1; m_fill = 0; m_match = 0; end
         end
         1: begin
            push_hist(d);
            if (d != pred || hist_zero()) begin
               m_mode = 0; m_fill = 0;
            end else begin
               m_match++;
               if (m_match == LC) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
            end
         end
         default: begin
            push_hist(pred);
            e = (d != pred);
            m_pulse = e;
            if (m_bcnt < SATMAX) m_bcnt++;
            if (e && m_ecnt < SATMAX) m_ecnt++;
            m_werr += int'(e);
            m_wpos++;
            if (m_werr == UE) begin
               m_mode = 0; m_fill = 0;
            end else if (m_wpos == UW) begin
               m_wpos = 0; m_werr = 0;
            end
         end
      endcase
      if (clr) begin m_ecnt = 0; m_bcnt = 0; end
      m_lock = (m_mode == 2);
   endtask

   task automatic cycle(input bit en, input bit rst, input bit d, input bit clr);
      sync_reset = rst; enable = en; data_in = d; clear_counts = clr;
      @(posedge clk);
      model_step(en, rst, d, clr);
      @(negedge clk);
      chk("locked", int'(locked), int'(m_lock));
      chk("error_pulse", int'(error_pulse), int'(m_pulse));
      chk("err_count", int'(err_count), m_ecnt);
      chk("bit_count", int'(bit_count), m_bcnt);
   endtask

   typedef struct {
      bit do_reset;
      int nbits;
      bit zeros;
      int flip_first;
      int flip_cnt;
      int flip_step;
      int gap_pct;
      int exp_rise;   // -2: not checked, -1: never rose
      int exp_fall;   // -1: never fell
      int exp_err;    // -2: not checked
      int exp_bits;   // -2: not checked
      int exp_lock;
   } scen_t;

   scen_t sc[7];

   initial begin
      int k, rise, fall, fpos;
      bit prev, b, f, en, rst, clr, burst;

      sc[0] = '{1, 200, 0,   0, 0, 1,  0, 31, -1, 0, 169, 1};   // clean lock
      sc[1] = '{1, 200, 0, 100, 1, 1,  0, 31, -1, 1, 169, 1};   // single flip
      sc[2] = '{1, 200, 0,  40, 8, 2,  0, 85, 54, 8, 138, 1};   // unlock + relock
      sc[3] = '{1, 100, 1,   0, 0, 1,  0, -1, -1, 0,   0, 0};   // all zeros
      sc[4] = '{0, 200, 0,   0, 0, 1,  0, -2, -1, 0,  -2, 1};   // clean after zeros
      sc[5] = '{1, 200, 0,   0, 0, 1, 30, 31, -1, 0, 169, 1};   // enable gaps
      sc[6] = '{1, 320, 0,   0, 0, 1,  0, 31, -1, 0, 255, 1};   // bit_count saturation

      for (int i = 0; i < 15; i++) stream.push_back(1'b1);
      for (int i = 15; i < 8192; i++) stream.push_back(stream[i-14] ^ stream[i-15]);

      model_reset();
      sync_reset = 1'b1; enable = 1'b0; data_in = 1'b0; clear_counts = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_pulse", int'(error_pulse), 0);
      chk("reset_err", int'(err_count), 0);
      chk("reset_bits", int'(bit_count), 0);

      sp = 0;
      for (int s = 0; s < 7; s++) begin
         if (sc[s].do_reset) begin
            cycle(1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)), 1'b0);
            sp = 0;
         end
         prev = locked; rise = -1; fall = -1; k = 0;
         while (k < sc[s].nbits) begin
            if (sc[s].gap_pct > 0 && $urandom_range(99) < sc[s].gap_pct) begin
               cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
            end else begin
               k++;
               b = sc[s].zeros ? 1'b0 : stream[sp];
               if (!sc[s].zeros) sp++;
               fpos = k - sc[s].flip_first;
               f = (sc[s].flip_cnt > 0) && (fpos >= 0) &&
                   (fpos < sc[s].flip_cnt * sc[s].flip_step) && (fpos % sc[s].flip_step == 0);
               cycle(1'b1, 1'b0, b ^ f, 1'b0);
               if (!prev && locked) rise = k;
               if (prev && !locked && fall < 0) fall = k;
               prev = locked;
            end
         end
         if (sc[s].exp_rise != -2) chk($sformatf("s%0d_rise_bit", s), rise, sc[s].exp_rise);
         chk($sformatf("s%0d_fall_bit", s), fall, sc[s].exp_fall);
         if (sc[s].exp_err != -2) chk($sformatf("s%0d_err", s), int'(err_count), sc[s].exp_err);
         if (sc[s].exp_bits != -2) chk($sformatf("s%0d_bits", s), int'(bit_count), sc[s].exp_bits);
         chk($sformatf("s%0d_locked", s), int'(locked), sc[s].exp_lock);
      end

      // clear_counts coinciding with an error: clear wins, pulse still fires
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      sp = 0;
      for (int i = 0; i < 40; i++) begin cycle(1'b1, 1'b0, stream[sp], 1'b0); sp++; end
      chk("pre_clear_locked", int'(locked), 1);
      chk("pre_clear_bits", int'(bit_count), 9);
      cycle(1'b1, 1'b0, ~stream[sp], 1'b1); sp++;
      chk("clear_err", int'(err_count), 0);
      chk("clear_bits", int'(bit_count), 0);
      chk("clear_pulse", int'(error_pulse), 1);
      cycle(1'b1, 1'b0, ~stream[sp], 1'b0); sp++;
      chk("post_clear_err", int'(err_count), 1);
      chk("post_clear_bits", int'(bit_count), 1);
      // frozen cycle with wrong data: no pulse, nothing moves
      cycle(1'b0, 1'b0, ~stream[sp], 1'b0);
      chk("frozen_pulse", int'(error_pulse), 0);
      chk("frozen_bits", int'(bit_count), 1);
      // reset while locked, enable low
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err_count), 0);

      // randomized run against the model
      sp = 0; burst = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) burst = ~burst;
         en  = ($urandom_range(9) != 0);
         rst = ($urandom_range(999) == 0);
         clr = ($urandom_range(1499) == 0);
         f   = burst ? ($urandom_range(4) == 0) : ($urandom_range(99) == 0);
         b   = stream[sp];
         if (en) sp++;
         cycle(en, rst, b ^ f, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
